// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared states, field codes and default tick counts for the front-panel controller
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_state_t;

  localparam logic FIELD_HR  = 1'b0;
  localparam logic FIELD_MIN = 1'b1;

  // Defaults for a 10 kHz clock
  localparam int DEF_DEBOUNCE_TICKS = 200;
  localparam int DEF_LONG_TICKS     = 10000;
  localparam int DEF_REPEAT_TICKS   = 2000;
  localparam int DEF_BLINK_TICKS    = 2500;
  localparam int DEF_TIMEOUT_TICKS  = 300000;

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - raw buttons in, counter control strobes out
interface clock_mode_ctrl_if;
  logic       btn_mode_raw;
  logic       btn_inc_raw;
  logic       enable;
  logic       setting_enable;
  logic       set_hr_or_min;
  logic       inc_short;
  logic       blink;
  logic [1:0] mode;

  modport master (
    input  btn_mode_raw, btn_inc_raw,
    output enable, setting_enable, set_hr_or_min, inc_short, blink, mode
  );

  modport slave (
    output btn_mode_raw, btn_inc_raw,
    input  enable, setting_enable, set_hr_or_min, inc_short, blink, mode
  );
endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// rtl/clock_mode_ctrl_btn_debounce.sv - 2-flop synchroniser, debounce counter and rise pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 200
) (
  input  logic clk_10000Hz,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // The DEBOUNCE_TICKS-th differing sample flips the level
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - RUN/SET_HR/SET_MIN sequencer with INC auto-repeat and blink; CLOCK_MODE_AUTO_EXIT_EN adds idle auto-exit
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter int BLINK_TICKS    = DEF_BLINK_TICKS,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS
) (
  input  logic               clk_10000Hz,
  input  logic               reset,
  clock_mode_ctrl_if.master  bus
);

  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  mode_state_t   state_q, state_d;
  logic          mode_level_unused;
  logic          mode_press;
  logic          inc_level;
  logic          inc_press;
  logic          fire;
  logic          timeout_hit;
  logic          wait_rel_q;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blink_cnt;
  logic          enable_q, setting_q, field_q, inc_q, blink_q;
  mode_state_t   mode_q;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_mode_db (
    .clk_10000Hz (clk_10000Hz),
    .reset       (reset),
    .btn_raw     (bus.btn_mode_raw),
    .level       (mode_level_unused),
    .press       (mode_press)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_inc_db (
    .clk_10000Hz (clk_10000Hz),
    .reset       (reset),
    .btn_raw     (bus.btn_inc_raw),
    .level       (inc_level),
    .press       (inc_press)
  );

`ifdef CLOCK_MODE_AUTO_EXIT_EN
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);

  logic [IW-1:0] idle_cnt;

  assign timeout_hit = (state_q != RUN) && !mode_press && !inc_press && !inc_level &&
                       (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state_q == RUN || mode_press || inc_press || inc_level || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_TICKS;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      RUN:     if (mode_press) state_d = SET_HR;
      SET_HR:  if (mode_press) state_d = SET_MIN; else if (timeout_hit) state_d = RUN;
      SET_MIN: if (mode_press) state_d = RUN;     else if (timeout_hit) state_d = RUN;
      default: state_d = RUN;
    endcase
    // MODE wins over INC, and a held INC stays silent until released
    if (state_q != RUN && !wait_rel_q && !mode_press && !timeout_hit) begin
      if (inc_press)
        fire = 1'b1;
      else if (inc_level && hold_cnt == HOLD_LAST)
        fire = 1'b1;
      else if (inc_level && hold_cnt == HOLD_MAX && rep_cnt == REP_LAST)
        fire = 1'b1;
    end
  end

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      mode_q     <= RUN;
      enable_q   <= 1'b1;
      setting_q  <= 1'b0;
      field_q    <= FIELD_HR;
      inc_q      <= 1'b0;
      wait_rel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= state_d;
      enable_q   <= (state_d == RUN);
      setting_q  <= (state_d != RUN);
      field_q    <= (state_d == SET_MIN) ? FIELD_MIN : FIELD_HR;
      inc_q      <= fire;
      if (!inc_level)
        wait_rel_q <= 1'b0;
      else if (state_d != state_q)
        wait_rel_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!inc_level || state_q == RUN || wait_rel_q || mode_press) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
    end
  end

  // Restarting on edits keeps the field steady right after a change
  always_ff @(posedge clk_10000Hz or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (state_d == RUN || state_d != state_q || fire) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.enable         = enable_q;
  assign bus.setting_enable = setting_q;
  assign bus.set_hr_or_min  = field_q;
  assign bus.inc_short      = inc_q;
  assign bus.blink          = blink_q;
  assign bus.mode           = mode_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - scoreboard bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

  logic clk_10000Hz = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;

  typedef struct {
    int         cyc;
    bit         is_inc;
    logic [1:0] mode;
    logic       en;
    logic       se;
    logic       hm;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] prev_mode = 2'd0;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(
    .DEBOUNCE_TICKS (4),
    .LONG_TICKS     (20),
    .REPEAT_TICKS   (5),
    .BLINK_TICKS    (3),
    .TIMEOUT_TICKS  (50)
  ) dut (
    .clk_10000Hz (clk_10000Hz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clk_10000Hz = ~clk_10000Hz;

  always @(posedge clk_10000Hz) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_mode(input int t, input logic [1:0] m, input logic en, input logic se,
                           input logic hm);
    ev_t e;
    e.cyc = t; e.is_inc = 1'b0; e.mode = m; e.en = en; e.se = se; e.hm = hm;
    exp_q.push_back(e);
  endtask

  task automatic push_inc(input int t);
    ev_t e;
    e.cyc = t; e.is_inc = 1'b1; e.mode = 2'd0; e.en = 1'b0; e.se = 1'b0; e.hm = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic observe(input bit is_inc);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got inc=%0d mode=%0d at cycle %0d, expected none",
               is_inc, bus.mode, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.is_inc != is_inc ||
          (!is_inc && (e.mode != bus.mode || e.en != bus.enable ||
                       e.se != bus.setting_enable || e.hm != bus.set_hr_or_min))) begin
        errors++;
        $display("FAIL event: got cyc=%0d inc=%0d mode=%0d en=%0d se=%0d hm=%0d expected cyc=%0d inc=%0d mode=%0d en=%0d se=%0d hm=%0d",
                 cyc, is_inc, bus.mode, bus.enable, bus.setting_enable, bus.set_hr_or_min,
                 e.cyc, e.is_inc, e.mode, e.en, e.se, e.hm);
      end
    end
  endtask

  always @(negedge clk_10000Hz) begin
    if (!reset) begin
      if (bus.mode != prev_mode) observe(1'b0);
      if (bus.inc_short) observe(1'b1);
    end
    prev_mode <= bus.mode;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_10000Hz);
  endtask

  task automatic press_mode(input logic [1:0] m, input logic en, input logic se, input logic hm);
    int s;
    s = cyc;
    push_mode(s + 7, m, en, se, hm);
    bus.btn_mode_raw = 1'b1;
    wait_until(s + 10);
    bus.btn_mode_raw = 1'b0;
    wait_until(s + 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, bus.enable, 1);
    check({tag, "_setting_enable"}, bus.setting_enable, 0);
    check({tag, "_set_hr_or_min"}, bus.set_hr_or_min, 0);
    check({tag, "_inc_short"}, bus.inc_short, 0);
    check({tag, "_blink"}, bus.blink, 0);
    check({tag, "_mode"}, bus.mode, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_mode_raw = 1'b0;
    bus.btn_inc_raw  = 1'b0;
    repeat (3) @(negedge clk_10000Hz);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_until(cyc + 5);

    // Three MODE presses, with a blink look inside SET_HR
    c = cyc;
    push_mode(c + 7, 2'd1, 1'b0, 1'b1, 1'b0);
    bus.btn_mode_raw = 1'b1;
    wait_until(c + 9);
    check("blink_before_toggle", bus.blink, 0);
    wait_until(c + 10);
    check("blink_after_toggle", bus.blink, 1);
    bus.btn_mode_raw = 1'b0;
    wait_until(c + 20);
    press_mode(2'd2, 1'b0, 1'b1, 1'b1);
    press_mode(2'd0, 1'b1, 1'b0, 1'b0);

    // Glitches shorter than the debounce window, then one real press
    repeat (3) begin
      bus.btn_mode_raw = 1'b1;
      wait_until(cyc + 3);
      bus.btn_mode_raw = 1'b0;
      wait_until(cyc + 3);
    end
    press_mode(2'd1, 1'b0, 1'b1, 1'b0);
    press_mode(2'd2, 1'b0, 1'b1, 1'b1);

    // INC long hold in SET_MIN: press pulse plus four repeats
    c = cyc;
    push_inc(c + 7);
    push_inc(c + 26);
    push_inc(c + 31);
    push_inc(c + 36);
    push_inc(c + 41);
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 38);
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 60);

    // INC ignored in RUN
    press_mode(2'd0, 1'b1, 1'b0, 1'b0);
    c = cyc;
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 10);
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 20);
    check("run_blink", bus.blink, 0);

    // INC held across SET_HR -> SET_MIN stays silent until re-pressed
    press_mode(2'd1, 1'b0, 1'b1, 1'b0);
    c = cyc;
    push_inc(c + 7);
    push_mode(c + 17, 2'd2, 1'b0, 1'b1, 1'b1);
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 10);
    bus.btn_mode_raw = 1'b1;
    wait_until(c + 15);
    bus.btn_mode_raw = 1'b0;
    wait_until(c + 60);
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 80);
    push_inc(c + 87);
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 90);
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 100);

    // Simultaneous MODE and INC press in SET_HR
    press_mode(2'd0, 1'b1, 1'b0, 1'b0);
    press_mode(2'd1, 1'b0, 1'b1, 1'b0);
    c = cyc;
    push_mode(c + 7, 2'd2, 1'b0, 1'b1, 1'b1);
    bus.btn_mode_raw = 1'b1;
    bus.btn_inc_raw  = 1'b1;
    wait_until(c + 10);
    bus.btn_mode_raw = 1'b0;
    bus.btn_inc_raw  = 1'b0;
    wait_until(c + 25);

    // Reset in the middle of auto-repeat
    c = cyc;
    push_inc(c + 7);
    push_inc(c + 26);
    push_inc(c + 31);
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 33);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 36);
    #2 reset = 1'b0;
    wait_until(c + 80);
    check("after_reset_mode", bus.mode, 0);
    check("after_reset_enable", bus.enable, 1);

`ifdef CLOCK_MODE_AUTO_EXIT_EN
    // Idle in SET_HR times out back to RUN
    c = cyc;
    push_mode(c + 7, 2'd1, 1'b0, 1'b1, 1'b0);
    push_mode(c + 57, 2'd0, 1'b1, 1'b0, 1'b0);
    bus.btn_mode_raw = 1'b1;
    wait_until(c + 10);
    bus.btn_mode_raw = 1'b0;
    wait_until(c + 60);
    check("timeout_blink", bus.blink, 0);
    check("timeout_enable", bus.enable, 1);
    wait_until(c + 70);

    // INC press late in the idle window restarts the timeout
    c = cyc;
    push_mode(c + 7, 2'd1, 1'b0, 1'b1, 1'b0);
    push_inc(c + 54);
    push_mode(c + 108, 2'd0, 1'b1, 1'b0, 1'b0);
    bus.btn_mode_raw = 1'b1;
    wait_until(c + 10);
    bus.btn_mode_raw = 1'b0;
    wait_until(c + 47);
    bus.btn_inc_raw = 1'b1;
    wait_until(c + 52);
    bus.btn_inc_raw = 1'b0;
    wait_until(c + 115);
    check("restart_timeout_blink", bus.blink, 0);
`else
    // Without auto-exit the set state persists
    press_mode(2'd1, 1'b0, 1'b1, 1'b0);
    wait_until(cyc + 100);
    check("persist_mode", bus.mode, 1);
    check("persist_setting_enable", bus.setting_enable, 1);
`endif

    wait_until(cyc + 10);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-panel controller for the time-of-day counter. It converts two raw push-buttons (MODE, INC) into the counter's control strobes: `enable`, `setting_enable`, `set_hr_or_min` and `inc_short`. It sequences the counter through RUN, SET_HR and SET_MIN, and generates single-cycle increment pulses, including auto-repeat on a long press. It sits between the board buttons and the counter, in the `clk_10000Hz` domain.

Parameters:
- DEBOUNCE_TICKS, 200: consecutive stable samples required before a debounced level changes (20 ms at 10 kHz).
- LONG_TICKS, 10000: INC hold time before auto-repeat starts (1 s).
- REPEAT_TICKS, 2000: auto-repeat pulse period once repeating (0.2 s).
- BLINK_TICKS, 2500: half-period of the blink output (2 Hz).
- TIMEOUT_TICKS, 300000: idle time before auto-exit (30 s); used only with CLOCK_MODE_AUTO_EXIT_EN.

Ports:
- clk_10000Hz  in  1  system clock, 10 kHz.
- reset  in  1  asynchronous, active-high reset.
- btn_mode_raw  in  1  raw MODE button, asynchronous, 1 = pressed.
- btn_inc_raw  in  1  raw INC button, asynchronous, 1 = pressed.
- enable  out  1  counter runs; 1 only in RUN.
- setting_enable  out  1  1 in SET_HR or SET_MIN.
- set_hr_or_min  out  1  0 = hour, 1 = minute; 1 only in SET_MIN.
- inc_short  out  1  exactly one-cycle increment strobe.
- blink  out  1  display blink for the field being set; 0 in RUN.
- mode  out  2  current state encoding (RUN = 0, SET_HR = 1, SET_MIN = 2).

Behaviour:
- Clock and reset: one clock, `clk_10000Hz`. Reset is asynchronous and active-high.
- Reset values: state RUN, `enable` = 1, `setting_enable` = 0, `set_hr_or_min` = 0, `inc_short` = 0, `blink` = 0, `mode` = 0. All counters and debounced levels clear to 0.
- Mid-operation reset: a reset asserted at any time (during a hold, during repeat, inside a set state) returns all of the above within the same cycle (asynchronous). No pulse is emitted on deassertion.
- Input synchronisation: each raw button passes through a 2-flop synchroniser.
- Debounce:
  - A per-button counter counts cycles in which the synchronised value differs from the debounced level.
  - When the counter reaches DEBOUNCE_TICKS, the debounced level toggles and the counter clears.
  - Any cycle in which the synchronised value equals the debounced level clears the counter.
- Press event: a 1-cycle rise of a debounced level. Total latency from a clean raw edge to the press event is 2 + DEBOUNCE_TICKS cycles.
- State machine (all registered outputs):
  - RUN → SET_HR on a MODE press.
  - SET_HR → SET_MIN on a MODE press.
  - SET_MIN → RUN on a MODE press.
  - No other transitions, except auto-exit when CLOCK_MODE_AUTO_EXIT_EN is defined.
- Output decode: registered from the next state, so outputs change in the cycle after the press event.
- INC handling in RUN: INC presses are ignored and `inc_short` stays 0.
- INC handling in SET_HR or SET_MIN:
  - A press emits one `inc_short` pulse in the cycle after the press event.
  - A hold counter then counts while the debounced INC stays 1.
  - When the hold counter reaches LONG_TICKS, a pulse is emitted, followed by one pulse every REPEAT_TICKS cycles until release.
  - Release clears the hold and repeat counters. No pulse is emitted on release.
- Simultaneous MODE and INC press events in the same cycle: MODE wins and no `inc_short` pulse is emitted.
- INC held across a state change: pulses are suppressed until INC has been released (a "wait-release" flag). This prevents a held INC from leaking into the new field.
- Counter widths: the hold counter saturates at LONG_TICKS and the repeat counter wraps at REPEAT_TICKS. Widths are `$clog2(param+1)`. No overflow is permitted.
- Blink:
  - Free-running counter of BLINK_TICKS; `blink` toggles on each terminal count while in a set state.
  - Forced to 0 and the counter is cleared in RUN.
  - The counter is restarted on every state change and on every `inc_short`, so a field being edited is visible immediately.

Optional Feature:
- Macro: CLOCK_MODE_AUTO_EXIT_EN.
- Defined:
  - An idle counter runs in SET_HR and SET_MIN.
  - It clears on any MODE or INC press event, and while INC is held.
  - On reaching TIMEOUT_TICKS the state returns to RUN, `blink` is forced to 0, and no `inc_short` is emitted.
- Undefined: the idle counter is absent, the set states persist indefinitely, and the TIMEOUT_TICKS parameter is unused.

Decomposition:
- Package `clock_ctrl_pkg`:
  - State enum: RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2.
  - Field constants: FIELD_HR = 1'b0, FIELD_MIN = 1'b1.
  - Default tick constants, as derived from 10 kHz.
- Sub-module `btn_debounce`: 2-flop synchroniser, debounce counter and rise-pulse output. Instantiated twice (MODE, INC), parameterised by DEBOUNCE_TICKS.
- The controller top holds the FSM, the press/repeat logic, blink and auto-exit.

Test Plan:
- Bench parameters: DEBOUNCE_TICKS = 4, LONG_TICKS = 20, REPEAT_TICKS = 5, BLINK_TICKS = 3, TIMEOUT_TICKS = 50.
- Reset, then three clean MODE presses → `mode` steps 0→1→2→0. `enable`/`setting_enable`/`set_hr_or_min` = 1/0/0, then 0/1/0, then 0/1/1, then 1/0/0. Each change occurs 2 + 4 + 1 cycles after the raw edge.
- MODE bounce of 3-cycle glitches, then a stable press → no state change from the glitches; exactly one transition.
- In SET_MIN, INC held for 40 cycles after debounce → exactly 5 `inc_short` single-cycle pulses: at press, hold 20, hold 25, hold 30 and hold 35. None on release.
- INC press in RUN → `inc_short` stays 0. INC held while MODE moves SET_HR→SET_MIN → no pulses until INC is released and pressed again.
- MODE and INC press events in the same cycle while in SET_HR → goes to SET_MIN, `inc_short` = 0. Reset asserted mid-repeat → outputs return to reset values immediately.
- With CLOCK_MODE_AUTO_EXIT_EN: enter SET_HR, idle 50 cycles → returns to RUN, `blink` = 0. An INC press at cycle 40 restarts the timeout.
